my_playback: RTL

- Pattern playback block: the transmit-side counterpart of the capture block.
- Host loads words into an internal dual_port_ram through a write port (port A). The block then streams them out on a valid/ready interface, either once or circularly, until stopped.
- Sits beside the capture block as a stimulus source for the design under test, and is controlled through the same register space.

---
 rtl/my_playback_if.sv | 22 ++
 rtl/my_playback.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/my_playback_if.sv
// my_playback_if: valid/ready stream carrying playback words.
//   master: drives playback_data / playback_data_valid, samples playback_ready
//   slave : samples playback_data / playback_data_valid, drives playback_ready
interface my_playback_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] playback_data;
  logic             playback_data_valid;
  logic             playback_ready;

  modport master (
    output playback_data,
    output playback_data_valid,
    input  playback_ready
  );

  modport slave (
    input  playback_data,
    input  playback_data_valid,
    output playback_ready
  );
endinterface

// File: rtl/my_playback.sv
// my_playback: pattern playback source. The host loads words into an internal
// RAM through a write port; the block then streams words 0..len-1 out on a
// valid/ready stream, once or circularly, until stopped or cleared.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   playback_wr*            host RAM write port (addresses >= PLAYBACK_SIZE dropped)
//   playback_length         words per pass, sampled at start
//   playback_start          start request (level or pulse)
//   playback_circular       wrap to word 0 after the last word, sampled at start
//   playback_stop           stop issuing reads, drain buffered words, then FINISH
//   playback_reset          abort and return to IDLE (highest priority)
//   stream                  output stream (data, valid, ready)
//   playback_size           constant RAM depth
//   playback_count          accepted words since last clear, saturating
//   playback_pos            next RAM read address
//   playback_busy           high while playing
//
// Optional feature macro: PLAYBACK_REPEAT_COUNT_EN adds playback_repeat[15:0];
// non-circular mode then plays playback_repeat+1 passes back to back.
module my_playback #(
  parameter int unsigned PLAYBACK_WIDTH = 32,
  parameter int unsigned PLAYBACK_SIZE  = 128
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      playback_wr,
  input  logic [31:0]               playback_wr_addr,
  input  logic [PLAYBACK_WIDTH-1:0] playback_wr_data,
  input  logic [31:0]               playback_length,
  input  logic                      playback_start,
  input  logic                      playback_circular,
  input  logic                      playback_stop,
  input  logic                      playback_reset,
`ifdef PLAYBACK_REPEAT_COUNT_EN
  input  logic [15:0]               playback_repeat,
`endif
  my_playback_if.master             stream,
  output logic [31:0]               playback_size,
  output logic [31:0]               playback_count,
  output logic [31:0]               playback_pos,
  output logic                      playback_busy
);

  localparam int unsigned AW     = $clog2(PLAYBACK_SIZE);
  localparam logic [31:0] SIZE32 = 32'(PLAYBACK_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [31:0]               len_q, len_d;
  logic                      circ_q, circ_d;
  logic [31:0]               pos_q, pos_d;
  logic [31:0]               count_q, count_d;
  logic                      stop_q, stop_d;
  logic                      done_q, done_d;
  logic                      rd_vld_q, rd_vld_d;
  logic                      head_vld_q, head_vld_d;
  logic [PLAYBACK_WIDTH-1:0] head_data_q, head_data_d;
  logic                      tail_vld_q, tail_vld_d;
  logic [PLAYBACK_WIDTH-1:0] tail_data_q, tail_data_d;
  logic                      busy_q, busy_d;
`ifdef PLAYBACK_REPEAT_COUNT_EN
  logic [15:0]               reps_q, reps_d;
`endif

  logic [PLAYBACK_WIDTH-1:0] mem [PLAYBACK_SIZE];
  logic [PLAYBACK_WIDTH-1:0] rd_data_q;
  logic                      wr_en;
  logic                      issue;
  logic                      pop;
  logic                      push;
  logic [1:0]                occ;

  assign wr_en = playback_wr && (playback_wr_addr < SIZE32);

  // Dual-port RAM: port A host write, port B 1-cycle synchronous read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[playback_wr_addr[AW-1:0]] <= playback_wr_data;
    if (issue) rd_data_q <= mem[pos_q[AW-1:0]];
  end

  // Next-state: 2-entry output buffer (head drives the stream), read issue, FSM.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    circ_d      = circ_q;
    pos_d       = pos_q;
    count_d     = count_q;
    stop_d      = stop_q;
    done_d      = done_q;
    rd_vld_d    = 1'b0;
    head_vld_d  = head_vld_q;
    head_data_d = head_data_q;
    tail_vld_d  = tail_vld_q;
    tail_data_d = tail_data_q;
`ifdef PLAYBACK_REPEAT_COUNT_EN
    reps_d      = reps_q;
`endif
    issue = 1'b0;
    pop   = head_vld_q && stream.playback_ready;
    push  = rd_vld_q;
    // Words held or in flight after this edge's pop; a new read needs a free slot.
    occ   = 2'(head_vld_q) + 2'(tail_vld_q) + 2'(rd_vld_q) - 2'(pop);

    if (pop) begin
      if (tail_vld_q) begin
        head_vld_d  = 1'b1;
        head_data_d = tail_data_q;
        tail_vld_d  = push;
        if (push) tail_data_d = rd_data_q;
      end else begin
        head_vld_d = push;
        if (push) head_data_d = rd_data_q;
      end
    end else if (push) begin
      if (head_vld_q) begin
        tail_vld_d  = 1'b1;
        tail_data_d = rd_data_q;
      end else begin
        head_vld_d  = 1'b1;
        head_data_d = rd_data_q;
      end
    end

    if (pop && (count_q != '1)) count_d = count_q + 32'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (playback_start && (playback_length != 32'd0)) begin
          state_d = ST_PLAY;
          len_d   = (playback_length > SIZE32) ? SIZE32 : playback_length;
          circ_d  = playback_circular;
          pos_d   = 32'd0;
          count_d = 32'd0;
          stop_d  = 1'b0;
          done_d  = 1'b0;
`ifdef PLAYBACK_REPEAT_COUNT_EN
          reps_d  = playback_repeat;
`endif
        end
      end
      ST_PLAY: begin
        stop_d = stop_q | playback_stop;
        if (!stop_d && !done_q && (occ < 2'd2)) begin
          issue    = 1'b1;
          rd_vld_d = 1'b1;
          if (pos_q == (len_q - 32'd1)) begin
            if (circ_q) begin
              pos_d = 32'd0;
            end
`ifdef PLAYBACK_REPEAT_COUNT_EN
            else if (reps_q != 16'd0) begin
              reps_d = reps_q - 16'd1;
              pos_d  = 32'd0;
            end
`endif
            else begin
              pos_d  = pos_q + 32'd1;
              done_d = 1'b1;
            end
          end else begin
            pos_d = pos_q + 32'd1;
          end
        end
        // Leave once nothing is buffered or in flight after this edge.
        if ((stop_d || done_d) && !head_vld_d && !issue) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_FINISH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (playback_reset) begin
      state_d    = ST_IDLE;
      rd_vld_d   = 1'b0;
      head_vld_d = 1'b0;
      tail_vld_d = 1'b0;
      pos_d      = 32'd0;
      count_d    = 32'd0;
      stop_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  assign busy_d = (state_d == ST_PLAY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      len_q       <= 32'd0;
      circ_q      <= 1'b0;
      pos_q       <= 32'd0;
      count_q     <= 32'd0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      head_vld_q  <= 1'b0;
      head_data_q <= '0;
      tail_vld_q  <= 1'b0;
      tail_data_q <= '0;
      busy_q      <= 1'b0;
`ifdef PLAYBACK_REPEAT_COUNT_EN
      reps_q      <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      circ_q      <= circ_d;
      pos_q       <= pos_d;
      count_q     <= count_d;
      stop_q      <= stop_d;
      done_q      <= done_d;
      rd_vld_q    <= rd_vld_d;
      head_vld_q  <= head_vld_d;
      head_data_q <= head_data_d;
      tail_vld_q  <= tail_vld_d;
      tail_data_q <= tail_data_d;
      busy_q      <= busy_d;
`ifdef PLAYBACK_REPEAT_COUNT_EN
      reps_q      <= reps_d;
`endif
    end
  end

  assign stream.playback_data       = head_data_q;
  assign stream.playback_data_valid = head_vld_q;
  assign playback_size              = SIZE32;
  assign playback_count             = count_q;
  assign playback_pos               = pos_q;
  assign playback_busy              = busy_q;

endmodule
